cpc_rombank_ctrl: RTL and testbench

CPC_ROMBANK_CTRL -- requirements
Module: cpc_rombank_ctrl

---
 rtl/cpc_rombank_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpc_rombank_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpc_rombank_ctrl.sv
// CPC upper-ROM bank decoder with a keyed write-unlock FSM for EEPROM programming.
// Latency: select write -> hit/idx visible two edges later; chip strobes are combinational; no backpressure.
module cpc_rombank_ctrl #(
    parameter int         NUM_CHIPS = 3,
    parameter logic [7:0] CTRL_PORT = 8'hFE,
    parameter int         TIMEOUT_W = 20
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic [7:0]           A,
    input  logic [7:0]           D,
    input  logic                 IOREQ_B,
    input  logic                 MREQ_B,
    input  logic                 WR_B,
    input  logic                 RD_B,
    input  logic                 ROMEN_B,
    input  logic [7:0]           dip,
    output logic [NUM_CHIPS-1:0] romcs_b,
    output logic                 romoe_b,
    output logic                 roma14,
    output logic                 romdis,
    output logic                 rom_we_b,
    output logic                 unlocked
);

    typedef enum logic [1:0] {LOCKED, KEY1, KEY2, UNLOCKED} state_t;

    localparam logic [7:0]           SLOTS   = 8'(2 * NUM_CHIPS);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [7:0] dip_m, dip_s;
    logic       io_wr, io_wr_q, wr_evt, sel_evt, ctrl_evt;
    logic [7:0] romsel, base, rel, idx;
    logic       hit;
    logic       upper_rd, mem_wr, we_act;
    logic [2:0] chip;

    state_t               state, state_d;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 pend, pend_d, we_q, tmo;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            dip_m <= 8'h00;
            dip_s <= 8'h00;
        end else begin
            dip_m <= dip;
            dip_s <= dip_m;
        end
    end

    // One event per I/O cycle no matter how many clocks the strobes stay low.
    assign io_wr    = !IOREQ_B && !WR_B;
    assign wr_evt   = io_wr && !io_wr_q;
    assign sel_evt  = wr_evt && !A[5];
    assign ctrl_evt = wr_evt && (A == CTRL_PORT);

    assign base = {4'h0, dip_s[3:0]};
    assign rel  = romsel - base;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            io_wr_q <= 1'b0;
            romsel  <= 8'h00;
            hit     <= 1'b0;
            idx     <= 8'h00;
        end else begin
            io_wr_q <= io_wr;
            if (sel_evt)
                romsel <= D;
            hit <= dip_s[4] && (romsel >= base) && (rel < SLOTS);
            idx <= rel;
        end
    end

    assign upper_rd = !ROMEN_B && (A[7:6] == 2'b11);
    assign mem_wr   = !MREQ_B && !WR_B && (A[7:6] == 2'b11);
    assign we_act   = (state == UNLOCKED) && hit && mem_wr;

    assign romdis   = hit && upper_rd;
    assign romoe_b  = !romdis;
    assign roma14   = idx[0];
    assign rom_we_b = !we_act;
    assign unlocked = (state == UNLOCKED);
    assign chip     = idx[3:1];

    for (genvar i = 0; i < NUM_CHIPS; i++) begin : g_cs
        assign romcs_b[i] = !((romdis || we_act) && (chip == 3'(i)));
    end

    assign tmo = &cnt;

    // Leaving UNLOCKED is held off (pend) until the current EEPROM write strobe ends.
    always_comb begin
        state_d = state;
        pend_d  = 1'b0;
        case (state)
            LOCKED: begin
                if (ctrl_evt && D == 8'hA5)
                    state_d = KEY1;
            end
            KEY1: begin
                if (ctrl_evt) begin
                    if (D == 8'h5A)      state_d = KEY2;
                    else if (D == 8'hA5) state_d = KEY1;
                    else                 state_d = LOCKED;
                end
            end
            KEY2: begin
                if (ctrl_evt) begin
                    if (D == 8'hC3)      state_d = UNLOCKED;
                    else if (D == 8'hA5) state_d = KEY1;
                    else                 state_d = LOCKED;
                end
            end
            UNLOCKED: begin
                if (ctrl_evt || tmo || pend) begin
                    if (rom_we_b) state_d = LOCKED;
                    else          pend_d  = 1'b1;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state <= LOCKED;
            pend  <= 1'b0;
            we_q  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pend  <= pend_d;
            we_q  <= rom_we_b;
            if (state != UNLOCKED || (we_q && !rom_we_b))
                cnt <= '0;
            else
                cnt <= cnt + CNT_ONE;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{RD_B, dip_s[7:5], idx[7:4]};

endmodule

// File: tb/tb_cpc_rombank_ctrl.sv
// Scoreboard bench for cpc_rombank_ctrl: 3 chips, dip base slot &0C, 4-bit unlock timeout.
module tb_cpc_rombank_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_B = 1'b0;
    logic [7:0] A, D, dip;
    logic       IOREQ_B, MREQ_B, WR_B, RD_B, ROMEN_B;
    logic [2:0] romcs_b;
    logic       romoe_b, roma14, romdis, rom_we_b, unlocked;

    cpc_rombank_ctrl #(.NUM_CHIPS(3), .CTRL_PORT(8'hFE), .TIMEOUT_W(4)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
        .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .WR_B(WR_B), .RD_B(RD_B), .ROMEN_B(ROMEN_B),
        .dip(dip), .romcs_b(romcs_b), .romoe_b(romoe_b), .roma14(roma14),
        .romdis(romdis), .rom_we_b(rom_we_b), .unlocked(unlocked)
    );

    always #5 CLK = ~CLK;

    // {romdis, romcs_b[2:0], roma14, romoe_b, rom_we_b, unlocked}
    logic [7:0] obs;
    assign obs = {romdis, romcs_b, roma14, romoe_b, rom_we_b, unlocked};

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef enum {AC_IDLE, AC_UPPER_RD, AC_LOWER_RD, AC_MEM_WR} acc_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop();
        sb_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk_eq(e.tag, obs, e.exp);
        end
    endtask

    task automatic idle();
        A = 8'h00; D = 8'h00;
        IOREQ_B = 1'b1; MREQ_B = 1'b1; WR_B = 1'b1; RD_B = 1'b1; ROMEN_B = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic drive(input acc_t m);
        idle();
        case (m)
            AC_UPPER_RD: begin A = 8'hC0; MREQ_B = 1'b0; RD_B = 1'b0; ROMEN_B = 1'b0; end
            AC_LOWER_RD: begin A = 8'h00; MREQ_B = 1'b0; RD_B = 1'b0; ROMEN_B = 1'b0; end
            AC_MEM_WR:   begin A = 8'hC0; MREQ_B = 1'b0; WR_B = 1'b0; end
            default: ;
        endcase
    endtask

    // Strobes held two clocks to exercise single-event detection.
    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        A = a; D = d; IOREQ_B = 1'b0; WR_B = 1'b0;
        step(2);
        idle();
        step(1);
    endtask

    task automatic probe(input string tag, input acc_t m, input logic [7:0] exp);
        drive(m);
        sb_push(tag, exp);
        @(negedge CLK);
        sb_pop();
        step(1);
        idle();
    endtask

    task automatic unlock_seq();
        io_write(8'hFE, 8'hA5);
        io_write(8'hFE, 8'h5A);
        io_write(8'hFE, 8'hC3);
    endtask

    initial begin
        idle();
        dip = 8'h1C;
        #12;
        sb_push("rst_hold", 8'b0_111_0_1_1_0);
        sb_pop();
        @(negedge CLK);
        RESET_B = 1'b1;
        step(4);
        probe("rst_idle", AC_UPPER_RD, 8'b0_111_0_1_1_0);

        io_write(8'hDF, 8'h0E);
        probe("sel0e_up", AC_UPPER_RD, 8'b1_101_0_0_1_0);
        probe("sel0e_lo", AC_LOWER_RD, 8'b0_111_0_1_1_0);
        io_write(8'hDF, 8'h0C);
        probe("slot0", AC_UPPER_RD, 8'b1_110_0_0_1_0);
        io_write(8'hDF, 8'h11);
        probe("slot5", AC_UPPER_RD, 8'b1_011_1_0_1_0);
        io_write(8'hDF, 8'h12);
        probe("above", AC_UPPER_RD, 8'b0_111_0_1_1_0);
        io_write(8'hDF, 8'h0B);
        probe("below", AC_UPPER_RD, 8'b0_111_1_1_1_0);
        io_write(8'h7F, 8'h0E);
        probe("a13_hi", AC_UPPER_RD, 8'b0_111_1_1_1_0);

        dip = 8'h0C;
        io_write(8'hDF, 8'h0E);
        step(2);
        probe("board_off", AC_UPPER_RD, 8'b0_111_0_1_1_0);
        dip = 8'h1C;
        step(3);
        probe("board_on", AC_UPPER_RD, 8'b1_101_0_0_1_0);

        io_write(8'hDF, 8'h0D);
        unlock_seq();
        probe("unlock", AC_IDLE, 8'b0_111_1_1_1_1);
        probe("rom_wr", AC_MEM_WR, 8'b0_110_1_1_0_1);
        probe("post_wr", AC_IDLE, 8'b0_111_1_1_1_1);
        io_write(8'hFE, 8'h00);
        probe("relock", AC_IDLE, 8'b0_111_1_1_1_0);

        io_write(8'hFE, 8'hA5);
        io_write(8'hFE, 8'h5A);
        io_write(8'hFE, 8'h77);
        probe("bad_key", AC_IDLE, 8'b0_111_1_1_1_0);
        probe("wr_locked", AC_MEM_WR, 8'b0_111_1_1_1_0);
        io_write(8'hFE, 8'hA5);
        unlock_seq();
        probe("rekey", AC_IDLE, 8'b0_111_1_1_1_1);

        io_write(8'hDF, 8'h20);
        probe("sel_miss", AC_MEM_WR, 8'b0_111_0_1_1_1);
        io_write(8'hDF, 8'h0E);
        probe("sel_new", AC_MEM_WR, 8'b0_101_0_1_0_1);
        io_write(8'hFE, 8'h00);
        probe("lock2", AC_IDLE, 8'b0_111_0_1_1_0);

        unlock_seq();
        step(6);
        probe("tmo_early", AC_IDLE, 8'b0_111_0_1_1_1);
        step(12);
        probe("tmo_idle", AC_IDLE, 8'b0_111_0_1_1_0);

        unlock_seq();
        drive(AC_MEM_WR);
        step(20);
        sb_push("tmo_hold", 8'b0_101_0_1_0_1);
        @(negedge CLK);
        sb_pop();
        @(posedge CLK);
        #2;
        idle();
        sb_push("tmo_rise", 8'b0_111_0_1_1_1);
        @(negedge CLK);
        sb_pop();
        step(1);
        sb_push("tmo_drop", 8'b0_111_0_1_1_0);
        @(negedge CLK);
        sb_pop();
        step(1);

        unlock_seq();
        drive(AC_MEM_WR);
        #1;
        sb_push("rst_pre", 8'b0_101_0_1_0_1);
        sb_pop();
        RESET_B = 1'b0;
        #1;
        sb_push("rst_mid", 8'b0_111_0_1_1_0);
        sb_pop();
        idle();
        step(2);
        RESET_B = 1'b1;
        step(4);
        probe("rst_romsel", AC_UPPER_RD, 8'b0_111_0_1_1_0);

        chk_eq("sb_drain", 8'(sb_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
